// File: rtl/dout_writer.sv
// Serialises eight 24-bit channel samples onto the DRDY/DCLK/DOUT0..3 TDM lines.
// Latency: DRDY rises at most 2*CLK_DIV clk_i cycles after start is accepted; a frame lasts 64 DCLK periods.
// Backpressure: ready_o is high only in IDLE; a start outside IDLE is dropped and flagged on overrun_o.
module dout_writer #(
  parameter int CLK_DIV   = 4,
  parameter int GAP_DCLKS = 4,
  parameter int CH_BITS   = 24
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [CH_BITS-1:0] ch1_i,
  input  logic [CH_BITS-1:0] ch2_i,
  input  logic [CH_BITS-1:0] ch3_i,
  input  logic [CH_BITS-1:0] ch4_i,
  input  logic [CH_BITS-1:0] ch5_i,
  input  logic [CH_BITS-1:0] ch6_i,
  input  logic [CH_BITS-1:0] ch7_i,
  input  logic [CH_BITS-1:0] ch8_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               overrun_o,
  output logic               drdy_o,
  output logic               dclk_o,
  output logic               dout0_o,
  output logic               dout1_o,
  output logic               dout2_o,
  output logic               dout3_o
);

  // State 0 is a one-cycle post-reset state so ready_o rises one cycle after release.
  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_DCLKS - 1);

  logic [2:0]       state;
  logic [15:0]      div_cnt;
  logic             dclk_q;
  logic [3:0][63:0] sr;
  logic [5:0]       bit_cnt;
  logic [15:0]      gap_cnt;
  logic             drdy_q;
  logic [3:0]       dout_q;
  logic             done_q;
  logic             overrun_q;
  logic             toggle;
  logic             rise;

  assign toggle = (div_cnt == DIV_LAST);
  // A rise event is the toggle that takes DCLK high; all line updates happen here.
  assign rise   = toggle && !dclk_q;

  assign ready_o   = (state == ST_IDLE);
  assign busy_o    = (state == ST_ARMED) || (state == ST_SHIFT) || (state == ST_GAP);
  assign done_o    = done_q;
  assign overrun_o = overrun_q;
  assign drdy_o    = drdy_q;
  assign dclk_o    = dclk_q;
  assign dout0_o   = dout_q[0];
  assign dout1_o   = dout_q[1];
  assign dout2_o   = dout_q[2];
  assign dout3_o   = dout_q[3];

  // Free-running DCLK divider: toggles every CLK_DIV cycles.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_cnt <= '0;
      dclk_q  <= 1'b0;
    end else if (toggle) begin
      div_cnt <= '0;
      dclk_q  <= ~dclk_q;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Frame sequencer: capture, DRDY marker, 64-bit MSB-first shift, inter-frame gap.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= ST_RST;
      sr        <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      drdy_q    <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= start_i && !ready_o;
      case (state)
        ST_RST: begin
          state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (start_i) begin
            // Each line carries two words: {0, ch_id, 4'b0, sample}.
            sr[0] <= {8'h00, ch1_i, 8'h10, ch2_i};
            sr[1] <= {8'h20, ch3_i, 8'h30, ch4_i};
            sr[2] <= {8'h40, ch5_i, 8'h50, ch6_i};
            sr[3] <= {8'h60, ch7_i, 8'h70, ch8_i};
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (rise) begin
            drdy_q  <= 1'b1;
            bit_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
              dout_q[i] <= sr[i][63];
              sr[i]     <= {sr[i][62:0], 1'b0};
            end
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise) begin
            drdy_q <= 1'b0;
            if (bit_cnt == 6'd63) begin
              dout_q  <= '0;
              done_q  <= 1'b1;
              gap_cnt <= '0;
              state   <= (GAP_DCLKS == 0) ? ST_IDLE : ST_GAP;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              for (int i = 0; i < 4; i++) begin
                dout_q[i] <= sr[i][63];
                sr[i]     <= {sr[i][62:0], 1'b0};
              end
            end
          end
        end
        ST_GAP: begin
          if (rise) begin
            if (gap_cnt == GAP_LAST) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dout_writer.sv
`timescale 1ns/1ps
// Directed bench for dout_writer: expected frames queued at acceptance, decoded and compared by a line monitor.
// Clocking: clk_i period 10 ns; stimulus drives 1 ns after the falling edge.
// The monitor samples DOUT on DCLK falling edges, as the receiver does.
module tb_dout_writer;

  localparam int CD  = 2;
  localparam int GAP = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] ch [8];
  logic        ready_o, busy_o, done_o, overrun_o, drdy_o, dclk_o;
  logic        dout0_o, dout1_o, dout2_o, dout3_o;

  dout_writer #(.CLK_DIV(CD), .GAP_DCLKS(GAP), .CH_BITS(24)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
    .drdy_o(drdy_o), .dclk_o(dclk_o),
    .dout0_o(dout0_o), .dout1_o(dout1_o), .dout2_o(dout2_o), .dout3_o(dout3_o)
  );

  always #5 clk_i = ~clk_i;

  // Directed samples and hand-computed line words (word 2k on line k first, then 2k+1).
  logic [23:0] smp  [4][8];
  logic [31:0] wexp [4][8];

  int compared = 0;
  int mismatched = 0;
  int exp_q [$];
  int cur_idx = 0;

  int cyc = 0, accept_cyc = 0, accepts = 0;
  int rises = 0, hi_cnt = 0, bitn = 0, frames_done = 0, done_cnt = 0, ovr_cnt = 0;
  bit in_frame = 0, last_valid = 0;
  logic dclk_prev = 0, drdy_prev = 0;
  logic [63:0] acc [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [9:0] outs();
    return {ready_o, busy_o, done_o, overrun_o, drdy_o, dclk_o, dout3_o, dout2_o, dout1_o, dout0_o};
  endfunction

  // Acceptance tracker: push the expected frame when start is taken.
  initial begin
    forever begin
      @(posedge clk_i);
      if (reset_ni && start_i && ready_o) begin
        accept_cyc = cyc;
        accepts++;
        exp_q.push_back(cur_idx);
      end
      cyc++;
    end
  end

  // Line monitor: DRDY timing, done timing, and frame decode on DCLK falls.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        in_frame = 0; last_valid = 0; rises = 0; hi_cnt = 0;
        dclk_prev = 0; drdy_prev = 0;
      end else begin
        if (overrun_o) ovr_cnt++;
        if (dclk_o && !dclk_prev) begin
          rises++;
          if (drdy_o && !drdy_prev) begin
            check_range("accept_to_drdy", cyc - accept_cyc - 1, 1, 2 * CD);
            if (last_valid) check_range("drdy_spacing", rises, 64 + GAP, 100000);
            rises = 0;
            last_valid = 1;
          end
        end
        if (done_o) begin
          done_cnt++;
          check("done_after_drdy", rises, 64);
        end
        if (drdy_o) hi_cnt++;
        else if (drdy_prev) begin
          check("drdy_width", hi_cnt, 2 * CD);
          hi_cnt = 0;
        end
        if (!dclk_o && dclk_prev) begin
          if (!in_frame && drdy_o) begin
            in_frame = 1;
            bitn = 0;
          end
          if (in_frame) begin
            acc[0] = {acc[0][62:0], dout0_o};
            acc[1] = {acc[1][62:0], dout1_o};
            acc[2] = {acc[2][62:0], dout2_o};
            acc[3] = {acc[3][62:0], dout3_o};
            bitn++;
            if (bitn == 64) begin
              in_frame = 0;
              frames_done++;
              if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_frame: got frame %0d expected none", frames_done);
              end else begin
                int idx;
                idx = exp_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                  check($sformatf("frame%0d_dout%0d_word0", frames_done, k), {32'h0, acc[k][63:32]}, {32'h0, wexp[idx][2*k]});
                  check($sformatf("frame%0d_dout%0d_word1", frames_done, k), {32'h0, acc[k][31:0]}, {32'h0, wexp[idx][2*k+1]});
                end
              end
            end
          end
        end
        dclk_prev = dclk_o;
        drdy_prev = drdy_o;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic load(input int idx);
    for (int i = 0; i < 8; i++) ch[i] = smp[idx][i];
    cur_idx = idx;
  endtask

  task automatic start_frame();
    int a0;
    int t;
    a0 = accepts;
    t = 0;
    start_i = 1'b1;
    tick();
    while (accepts == a0 && t < 200) begin
      tick();
      t++;
    end
    start_i = 1'b0;
    check("start_accepted", accepts, a0 + 1);
  endtask

  task automatic wait_drdy();
    int t;
    t = 0;
    while (!drdy_o && t < 200) begin
      tick();
      t++;
    end
    check("drdy_seen", drdy_o, 1);
  endtask

  task automatic wait_rises(input int n);
    int t;
    t = 0;
    while (rises < n && t < 1000) begin
      tick();
      t++;
    end
    check_range("rises_reached", rises, n, n);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 2000) begin
      tick();
      t++;
    end
    check("frames_reached", frames_done, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s [16];
    int viol;
    int a0;
    int o0;

    smp[0]  = '{24'h123456, 24'hFEDCBA, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h800000};
    wexp[0] = '{32'h00123456, 32'h10FEDCBA, 32'h20000000, 32'h30000000, 32'h40000000, 32'h50000000, 32'h60000000, 32'h70800000};
    smp[1]  = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666, 24'h777777, 24'h888888};
    wexp[1] = '{32'h00111111, 32'h10222222, 32'h20333333, 32'h30444444, 32'h40555555, 32'h50666666, 32'h60777777, 32'h70888888};
    smp[2]  = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    wexp[2] = '{32'h00FFFFFF, 32'h10FFFFFF, 32'h20FFFFFF, 32'h30FFFFFF, 32'h40FFFFFF, 32'h50FFFFFF, 32'h60FFFFFF, 32'h70FFFFFF};
    smp[3]  = '{24'hA5A5A5, 24'h5A5A5A, 24'h000001, 24'h7FFFFF, 24'h800001, 24'hC0FFEE, 24'h0F0F0F, 24'hF0F0F0};
    wexp[3] = '{32'h00A5A5A5, 32'h105A5A5A, 32'h20000001, 32'h307FFFFF, 32'h40800001, 32'h50C0FFEE, 32'h600F0F0F, 32'h70F0F0F0};
    for (int i = 0; i < 8; i++) ch[i] = 24'h0;

    // Reset state and ready timing.
    tick(); tick(); tick();
    check("reset_outputs", {54'h0, outs()}, 64'h0);
    reset_ni = 1'b1;
    #1;
    check("ready_at_release", ready_o, 0);
    tick();
    check("ready_after_release", ready_o, 1);

    // DCLK period 4 / 50 % duty, all other lines idle before the first start.
    viol = 0;
    for (int k = 0; k < 16; k++) begin
      s[k] = dclk_o;
      if ({busy_o, done_o, overrun_o, drdy_o, dout3_o, dout2_o, dout1_o, dout0_o} != 8'h0) viol++;
      tick();
    end
    check("idle_lines_before_start", viol, 0);
    viol = 0;
    for (int k = 0; k < 14; k++) if (s[k+2] == s[k]) viol++;
    check("dclk_period4_duty50", viol, 0);

    // Single frame.
    load(0);
    start_frame();
    check("busy_after_accept", busy_o, 1);
    wait_frames(1);

    // Overrun at bit 10; inputs scrambled after capture.
    load(1);
    start_frame();
    for (int i = 0; i < 8; i++) ch[i] = 24'hDEAD00 + 24'(i);
    wait_drdy();
    wait_rises(10);
    o0 = ovr_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    check("overrun_pulses", ovr_cnt - o0, 1);
    wait_frames(2);

    // Back-to-back with start held high.
    load(2);
    a0 = accepts;
    start_i = 1'b1;
    for (int t = 0; t < 2000 && accepts < a0 + 2; t++) tick();
    start_i = 1'b0;
    check("held_start_captures", accepts - a0, 2);
    wait_frames(4);

    // Reset at bit 40, then a clean frame.
    load(1);
    start_frame();
    wait_drdy();
    wait_rises(40);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_reset_outputs", {54'h0, outs()}, 64'h0);
    tick(); tick(); tick();
    exp_q.delete();
    reset_ni = 1'b1;
    #1;
    check("post_reset_idle", {54'h0, outs()}, 64'h0);
    tick();
    load(3);
    start_frame();
    wait_frames(5);

    tick(); tick(); tick(); tick(); tick(); tick();
    check("done_count", done_cnt, 5);
    check("accept_count", accepts, 6);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dout_writer.md
Name: dout_writer

Overview:
- Transmit-side twin of the TDM ADC receiver. It serialises eight 24-bit channel samples onto the four-line DRDY/DCLK/DOUT interface that the receiver decodes.
- Used for hardware-in-the-loop checks (PMOD loopback into the receiver) and as the stimulus model in receiver benches.
- Frame format is bit-compatible with the receiver's ch1..ch8 mapping.

Parameters:
- CLK_DIV, 4: clk_i cycles per DCLK half-period. Minimum 1. DCLK period = 2*CLK_DIV clk_i cycles.
- GAP_DCLKS, 4: minimum idle DCLK periods between the end of one frame and the next DRDY. Minimum 0.
- CH_BITS, 24: sample width per channel. Fixed at 24; other values are unsupported.

Ports:
- clk_i in 1: system clock.
- reset_ni in 1: asynchronous, active-low reset.
- start_i in 1: request a frame. Samples are captured on the cycle start_i && ready_o.
- ch1_i..ch8_i in 24 each: signed samples, captured on an accepted start.
- ready_o out 1: high only in IDLE; start is accepted this cycle.
- busy_o out 1: high from the cycle after acceptance until the return to IDLE.
- done_o out 1: one-cycle pulse when the last bit period of a frame ends.
- overrun_o out 1: one-cycle pulse when start_i is high while ready_o is low.
- drdy_o out 1: frame marker.
- dclk_o out 1: serial clock.
- dout0_o..dout3_o out 1 each: serial data lines.

Behaviour:
- Reset: every output and all state = 0. The FSM enters IDLE, and ready_o rises one cycle after reset release.
- DCLK: free-running after reset.
  - div_cnt counts 0..CLK_DIV-1; dclk_o toggles when div_cnt == CLK_DIV-1.
  - A "rise event" is a toggle cycle with dclk_o == 0 before the toggle.
- All data outputs are registered and change only on rise-event cycles, together with dclk_o going high. The receiver samples on the DCLK falling edge.
- Word format: 32 bits, MSB first.
  - Bits [31:24] = header {1'b0, ch_id[2:0], 4'b0000}, with ch_id = channel number - 1.
  - Bits [23:0] = sample.
- Line mapping:
  - dout0: ch1 then ch2.
  - dout1: ch3 then ch4.
  - dout2: ch5 then ch6.
  - dout3: ch7 then ch8.
  - Each line carries 64 bits per frame.
- FSM:
  - IDLE: ready_o = 1. On start_i, capture ch1..ch8 into four 64-bit shift registers and go to ARMED.
  - ARMED: wait for the next rise event, then go to SHIFT.
    - On that event: drdy_o = 1, each dout = MSB of its line, bit_cnt = 0.
    - Accept-to-DRDY latency ≤ 2*CLK_DIV clk cycles.
  - SHIFT: on each rise event, bit_cnt increments and the next bit is presented.
    - drdy_o returns to 0 at the second rise event, so it is high for exactly one DCLK period.
    - When the rise event ends bit 63: dout = 0, pulse done_o, go to GAP, or to IDLE if GAP_DCLKS == 0.
  - GAP: count GAP_DCLKS rise events, then go to IDLE.
- start_i while not in IDLE is ignored: no capture, and overrun_o pulses for every such cycle. start_i held high across the IDLE cycle is accepted once, then counted as overrun in the following cycles.
- Inputs change freely after capture; a frame in flight is unaffected.
- reset_ni low mid-frame clears everything immediately. After release, the line is idle with dclk_o = 0 and no partial frame is resumed.
- Frame period at back-to-back starts ≥ (64 + GAP_DCLKS) DCLK periods.

Test Plan:
- Reset and DCLK: CLK_DIV = 2 → dclk_o period 4 clk cycles with 50 % duty; all other outputs are 0 during reset and until the first start.
- Single frame loopback: ch1 = 24'h123456, ch2 = 24'hFEDCBA, ch8 = 24'h800000, start once.
  - dout0 serialises 32'h00123456 then 32'h10FEDCBA.
  - dout3 second word = 32'h70800000.
  - Receiver instance outputs match the inputs sign-extended.
  - done_o pulses once, 64 DCLK periods after DRDY rises.
- DRDY timing: drdy_o is high for exactly 2*CLK_DIV clk cycles, coincident with bit 31 of the first word; accept-to-DRDY latency ≤ 4 cycles at CLK_DIV = 2.
- Overrun: start_i pulsed at bit 10 of a frame → overrun_o pulses once, and the frame data and the length of 64 bits are unchanged.
- Back-to-back: start_i held high, GAP_DCLKS = 4 → DRDY rises are ≥ 68 DCLK periods apart; exactly one capture per frame.
- Reset mid-frame: assert reset_ni at bit 40 → outputs go to 0 asynchronously, and the next frame after release is complete and correct.
